// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer definitions and Gray helpers, used by both the
// read-side empty controller and the write-side full controller.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int PTR_W           = FIFO_ADDR_WIDTH + 1;
    localparam int CONV_W          = 32;

    typedef logic [PTR_W-1:0] ptr_t;

    // Both conversions are width-agnostic: zero-extended inputs convert
    // correctly, so callers cast to CONV_W and size-cast the result back.
    function automatic logic [CONV_W-1:0] bin2grey(input logic [CONV_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [CONV_W-1:0] grey2bin(input logic [CONV_W-1:0] g);
        logic [CONV_W-1:0] b;
        b[CONV_W-1] = g[CONV_W-1];
        for (int i = CONV_W-2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Plain flop chain for carrying a Gray pointer across clock domains.
// No logic between stages; every stage clears on async active-low reset.
module ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_sync <= '0;
        else
            r_sync <= {r_sync[STAGES-2:0], i_d};
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/rd_empty_ctrl.sv
// Read-domain end of the async FIFO pointer crossing: synchronised write
// pointer, registered empty / level / almost-empty, sticky underflow, Rinc gate.
module rd_empty_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic                R_CLK,
    input  logic                RST,
    input  logic [ADDR_WIDTH:0] wr_ptr_grey,
    input  logic [ADDR_WIDTH:0] rd_ptr_bin,
    input  logic                rd_req,
    output logic                Rinc,
    output logic                empty,
    output logic                almost_empty,
    output logic [ADDR_WIDTH:0] rd_level,
    output logic                underflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

    logic [PW-1:0] w_wq_grey;
    logic [PW-1:0] w_wq_bin;
    logic [PW-1:0] w_rd_next_bin;
    logic [PW-1:0] w_rd_next_grey;
    logic [PW-1:0] w_level;

    logic          r_empty;
    logic          r_almost_empty;
    logic [PW-1:0] r_level;
    logic          r_underflow;

    ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .i_clk   (R_CLK),
        .i_rst_n (RST),
        .i_d     (wr_ptr_grey),
        .o_q     (w_wq_grey)
    );

    // Gated by the registered flag, so a read can never pass the write pointer.
    assign Rinc = rd_req & ~r_empty;

    assign w_rd_next_bin  = rd_ptr_bin + {{(PW-1){1'b0}}, Rinc};
    assign w_rd_next_grey = PW'(bin2grey(CONV_W'(w_rd_next_bin)));
    assign w_wq_bin       = PW'(grey2bin(CONV_W'(w_wq_grey)));
    assign w_level        = w_wq_bin - w_rd_next_bin;

    // Flags track the post-edge read pointer so the last read empties with no bubble.
    always_ff @(posedge R_CLK or negedge RST) begin
        if (!RST) begin
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_level        <= '0;
            r_underflow    <= 1'b0;
        end else begin
            r_empty        <= (w_rd_next_grey == w_wq_grey);
            r_almost_empty <= (w_level <= AE_T);
            r_level        <= w_level;
            if (rd_req && r_empty)
                r_underflow <= 1'b1;
        end
    end

    assign empty        = r_empty;
    assign almost_empty = r_almost_empty;
    assign rd_level     = r_level;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_rd_empty_ctrl.sv
// Bench for rd_empty_ctrl: binary-arithmetic reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_rd_empty_ctrl;

    localparam int SYNC = 2;
    localparam int AE   = 2;

    logic       R_CLK = 1'b0;
    logic       RST   = 1'b1;
    logic [4:0] wr_ptr_grey = '0;
    logic [4:0] rd_ptr_bin  = '0;
    logic       rd_req      = 1'b0;
    logic       Rinc, empty, almost_empty, underflow;
    logic [4:0] rd_level;

    logic [4:0] tb_wr_bin = '0;

    int n_checks = 0;
    int n_errors = 0;

    rd_empty_ctrl #(.ADDR_WIDTH(4), .SYNC_STAGES(SYNC), .AE_THRESH(AE)) dut (
        .R_CLK        (R_CLK),
        .RST          (RST),
        .wr_ptr_grey  (wr_ptr_grey),
        .rd_ptr_bin   (rd_ptr_bin),
        .rd_req       (rd_req),
        .Rinc         (Rinc),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_level     (rd_level),
        .underflow    (underflow)
    );

    always #5 R_CLK = ~R_CLK;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    task automatic set_wr(input logic [4:0] g, input logic [4:0] b);
        wr_ptr_grey = g;
        tb_wr_bin   = b;
    endtask

    // Reference model: the read side sees the write pointer as it was SYNC
    // edges ago; level is plain modular distance to the post-edge read pointer.
    int unsigned m_hist[$];
    int unsigned m_wq, m_nxt, m_level;
    bit          m_empty, m_ae, m_uf;

    task automatic m_reset();
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back(0);
        m_level = 0;
        m_empty = 1'b1;
        m_ae    = 1'b1;
        m_uf    = 1'b0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge R_CLK or negedge RST);
            if (!RST) begin
                m_reset();
            end else begin
                m_wq  = m_hist.pop_front();
                m_nxt = rd_ptr_bin + ((rd_req && !m_empty) ? 1 : 0);
                m_hist.push_back(tb_wr_bin);
                if (rd_req && m_empty) m_uf = 1'b1;
                m_level = (m_wq - m_nxt) % 32;
                m_empty = (m_level == 0);
                m_ae    = (m_level <= AE);
            end
            #1;
            chk("model_empty", 32'(empty), 32'(m_empty));
            chk("model_ae",    32'(almost_empty), 32'(m_ae));
            chk("model_level", 32'(rd_level), m_level);
            chk("model_uf",    32'(underflow), 32'(m_uf));
            chk("model_rinc",  32'(Rinc), 32'(rd_req && !m_empty));
        end
    end

    initial begin
        // 1. Reset, with a request pending
        rd_req = 1'b1;
        #1 RST = 1'b0;
        #2;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ae",    32'(almost_empty), 32'd1);
        chk("rst_level", 32'(rd_level), 32'd0);
        chk("rst_uf",    32'(underflow), 32'd0);
        chk("rst_rinc",  32'(Rinc), 32'd0);
        @(negedge R_CLK);
        RST = 1'b1;
        rd_req = 1'b0;
        repeat (2) @(negedge R_CLK);

        // 2. One write, exact latency, then a single read
        set_wr(5'b00001, 5'd1);
        repeat (2) @(negedge R_CLK);
        chk("lat_e2_empty", 32'(empty), 32'd1);
        @(negedge R_CLK);
        chk("lat_e3_empty", 32'(empty), 32'd0);
        chk("lat_e3_level", 32'(rd_level), 32'd1);
        rd_req = 1'b1;
        #1 chk("one_rinc", 32'(Rinc), 32'd1);
        @(negedge R_CLK);
        chk("one_empty", 32'(empty), 32'd1);
        chk("one_level", 32'(rd_level), 32'd0);
        chk("one_uf",    32'(underflow), 32'd0);
        rd_req = 1'b0;
        rd_ptr_bin = 5'd1;

        // 3. Full FIFO, then three reads
        set_wr(5'b11000, 5'd16);
        rd_ptr_bin = 5'd0;
        repeat (3) @(negedge R_CLK);
        chk("fill_level", 32'(rd_level), 32'd16);
        chk("fill_ae",    32'(almost_empty), 32'd0);
        chk("fill_empty", 32'(empty), 32'd0);
        rd_req = 1'b1;
        repeat (3) begin
            @(negedge R_CLK);
            rd_ptr_bin = rd_ptr_bin + 5'd1;
        end
        rd_req = 1'b0;
        chk("rd3_level", 32'(rd_level), 32'd13);

        // 4. Wrap-around of both pointers
        rd_ptr_bin = 5'd31;
        set_wr(5'b00000, 5'd0);
        repeat (3) @(negedge R_CLK);
        chk("wrap_level", 32'(rd_level), 32'd1);
        chk("wrap_ae",    32'(almost_empty), 32'd1);
        rd_req = 1'b1;
        #1 chk("wrap_rinc", 32'(Rinc), 32'd1);
        @(negedge R_CLK);
        rd_req = 1'b0;
        rd_ptr_bin = 5'd0;
        chk("wrap_empty", 32'(empty), 32'd1);
        chk("wrap_lvl0",  32'(rd_level), 32'd0);

        // 5. Underflow is sticky across later writes
        rd_req = 1'b1;
        #1 chk("uf_rinc", 32'(Rinc), 32'd0);
        @(negedge R_CLK);
        chk("uf_set", 32'(underflow), 32'd1);
        rd_req = 1'b0;
        set_wr(5'b00010, 5'd3);
        repeat (3) @(negedge R_CLK);
        chk("uf_lvl3", 32'(rd_level), 32'd3);
        chk("uf_hold", 32'(underflow), 32'd1);

        // 6. Reset in the middle of a read
        set_wr(5'b00111, 5'd5);
        repeat (3) @(negedge R_CLK);
        chk("mid_level5", 32'(rd_level), 32'd5);
        rd_req = 1'b1;
        #2;
        RST = 1'b0;
        set_wr(5'b00000, 5'd0);
        rd_ptr_bin = 5'd0;
        #1;
        chk("mid_empty", 32'(empty), 32'd1);
        chk("mid_ae",    32'(almost_empty), 32'd1);
        chk("mid_level", 32'(rd_level), 32'd0);
        chk("mid_uf",    32'(underflow), 32'd0);
        chk("mid_rinc",  32'(Rinc), 32'd0);
        @(negedge R_CLK);
        RST = 1'b1;
        rd_req = 1'b0;
        repeat (4) @(negedge R_CLK);
        chk("post_empty", 32'(empty), 32'd1);
        chk("post_uf",    32'(underflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
